// File: rtl/axum_ctx_sched.sv
// Round-robin hardware context scheduler for the multi-context register file.
// The select only moves while the core is halted and drained, so in-flight work never sees it change.
module axum_ctx_sched #(
  parameter int NumRegFiles = 4,
  parameter int SliceWidth  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumRegFiles-1:0]         ctx_ready_i,
  input  logic [SliceWidth-1:0]          slice_len_i,
  input  logic                           yield_i,
  input  logic                           halted_i,
  output logic                           halt_req_o,
  output logic [$clog2(NumRegFiles)-1:0] ctx_sel_o,
  output logic                           switch_o,
  output logic                           idle_o,
  output logic [SliceWidth-1:0]          slice_cnt_o
);

  localparam int SelW = $clog2(NumRegFiles);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSwitch = 2'd1,
    StRun    = 2'd2,
    StDrain  = 2'd3
  } state_e;

  state_e                state_q;
  logic [SelW-1:0]       ctx_sel_q;
  logic                  halt_req_q;
  logic                  switch_q;
  logic [SliceWidth-1:0] slice_cnt_q;

  logic [SelW-1:0]       nxt;
  logic [SelW-1:0]       cand;
  logic                  found;
  logic                  run_leave;

  // Scan from the context after the current one; walking downwards lets the
  // nearest ready candidate win, so the current context is chosen last.
  always_comb begin
    nxt   = ctx_sel_q;
    cand  = ctx_sel_q;
    found = |ctx_ready_i;
    for (int i = NumRegFiles - 1; i >= 0; i--) begin
      cand = ctx_sel_q + SelW'(i + 1);
      if (ctx_ready_i[cand]) begin
        nxt = cand;
      end
    end
  end

  assign run_leave = yield_i
                   || (slice_cnt_q == SliceWidth'(1))
                   || !ctx_ready_i[ctx_sel_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ctx_sel_q   <= '0;
      halt_req_q  <= 1'b1;
      switch_q    <= 1'b0;
      slice_cnt_q <= '0;
    end else begin
      switch_q <= 1'b0;
      case (state_q)
        StIdle: begin
          halt_req_q <= 1'b1;
          if (found) begin
            ctx_sel_q <= nxt;
            switch_q  <= (nxt != ctx_sel_q);
            state_q   <= StSwitch;
          end
        end
        // Select has been stable for this whole cycle; release the core next.
        StSwitch: begin
          halt_req_q  <= 1'b0;
          slice_cnt_q <= slice_len_i;
          state_q     <= StRun;
        end
        StRun: begin
          if (slice_cnt_q > SliceWidth'(1)) begin
            slice_cnt_q <= slice_cnt_q - SliceWidth'(1);
          end
          if (run_leave) begin
            halt_req_q <= 1'b1;
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          halt_req_q <= 1'b1;
          if (halted_i) begin
            if (found) begin
              ctx_sel_q <= nxt;
              switch_q  <= (nxt != ctx_sel_q);
              state_q   <= StSwitch;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          halt_req_q <= 1'b1;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign halt_req_o  = halt_req_q;
  assign ctx_sel_o   = ctx_sel_q;
  assign switch_o    = switch_q;
  assign slice_cnt_o = slice_cnt_q;
  assign idle_o      = (state_q == StIdle);

endmodule
